// File: rtl/spi_display_master.sv
// SPI master: queues 4-bit address / 8-bit data writes and shifts them out as
// 16-bit frames {4'b0001, addr, data}, MSB first. `SPI_MASTER_FIFO_EN selects a
// FIFO_DEPTH-entry queue; otherwise a single holding register is used.
module spi_display_master #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       block_clk_i,
    input  logic       rst_low_i,
    input  logic       req_valid_i,
    input  logic [3:0] req_addr_i,
    input  logic [7:0] req_data_i,
    output logic       req_ready_o,
    output logic       busy_o,
    output logic       spi_sclk_o,
    output logic       spi_ss_o,
    output logic       spi_mosi_o
);

    if (CLK_DIV < 2 || GAP_CYCLES < 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("spi_display_master: invalid parameter set");
    end

    localparam int unsigned PH_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int unsigned PH_W   = $clog2(PH_MAX) + 1;
    localparam logic [PH_W-1:0] DIV_LOAD = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0] GAP_LOAD = PH_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LOW,
        S_HIGH,
        S_HOLD,
        S_GAP
    } state_e;

    state_e            state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [15:0]       shift_q, shift_d;
    logic [3:0]        bit_q, bit_d;
    logic              sclk_q, sclk_d;
    logic              ss_q, ss_d;
    logic              mosi_q, mosi_d;
    logic              busy_q, busy_d;

    logic              q_push, q_pop, q_full, q_empty;
    logic [11:0]       q_head;

    // Ready is forced low while reset is held so no request slips in.
    assign req_ready_o = rst_low_i && !q_full;
    assign q_push      = req_valid_i && req_ready_o;
    assign q_pop       = (state_q == S_IDLE) && !q_empty;

`ifdef SPI_MASTER_FIFO_EN
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    logic [11:0]      mem_q [FIFO_DEPTH];
    logic [11:0]      mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    assign q_full  = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
    assign q_empty = (count_q == '0);
    assign q_head  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (q_push) begin
            mem_d[wr_ptr_q] = {req_addr_i, req_data_i};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (q_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({q_push, q_pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge block_clk_i or negedge rst_low_i) begin
        if (!rst_low_i) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
`else
    logic [11:0] hold_q, hold_d;
    logic        hold_vld_q, hold_vld_d;

    assign q_full  = hold_vld_q;
    assign q_empty = !hold_vld_q;
    assign q_head  = hold_q;

    always_comb begin
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        if (q_push) begin
            hold_d     = {req_addr_i, req_data_i};
            hold_vld_d = 1'b1;
        end else if (q_pop) begin
            hold_vld_d = 1'b0;
        end
    end

    always_ff @(posedge block_clk_i or negedge rst_low_i) begin
        if (!rst_low_i) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        unique case (state_q)
            S_IDLE: begin
                if (!q_empty) begin
                    state_d = S_SETUP;
                    phase_d = DIV_LOAD;
                    shift_d = {4'b0001, q_head};
                    bit_d   = 4'd15;
                end
            end
            S_SETUP, S_LOW: begin
                if (phase_q == '0) begin
                    state_d = (state_q == S_SETUP) ? S_LOW : S_HIGH;
                    phase_d = DIV_LOAD;
                end else begin
                    phase_d = phase_q - PH_W'(1);
                end
            end
            S_HIGH: begin
                if (phase_q == '0) begin
                    phase_d = DIV_LOAD;
                    if (bit_q == 4'd0) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_LOW;
                        bit_d   = bit_q - 4'd1;
                        shift_d = {shift_q[14:0], 1'b0};
                    end
                end else begin
                    phase_d = phase_q - PH_W'(1);
                end
            end
            S_HOLD: begin
                if (phase_q == '0) begin
                    state_d = S_GAP;
                    phase_d = GAP_LOAD;
                end else begin
                    phase_d = phase_q - PH_W'(1);
                end
            end
            S_GAP: begin
                if (phase_q == '0) begin
                    state_d = S_IDLE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q - PH_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                phase_d = '0;
            end
        endcase
    end

    // Pin flops follow the registered state, so every pin lags the FSM by one
    // cycle uniformly and phase lengths on the wire match the state lengths.
    always_comb begin
        sclk_d = (state_q != S_LOW);
        ss_d   = (state_q == S_IDLE) || (state_q == S_GAP);
        mosi_d = ss_d ? 1'b1 : shift_q[15];
        busy_d = (state_q != S_IDLE) || !q_empty;
    end

    always_ff @(posedge block_clk_i or negedge rst_low_i) begin
        if (!rst_low_i) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            shift_q <= '0;
            bit_q   <= '0;
            sclk_q  <= 1'b1;
            ss_q    <= 1'b1;
            mosi_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            sclk_q  <= sclk_d;
            ss_q    <= ss_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
        end
    end

    assign spi_sclk_o = sclk_q;
    assign spi_ss_o   = ss_q;
    assign spi_mosi_o = mosi_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_spi_display_master.sv
// Bench for spi_display_master: default instance plus a CLK_DIV=2/GAP=2 instance,
// each watched by an SPI slave model that decodes frames and times the waveform.
module tb_spi_display_master;

    localparam int P0 = 34 * 4 + 4 + 1;
    localparam int P1 = 34 * 2 + 2 + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [1:0]      vld;
    logic [1:0][3:0] adr;
    logic [1:0][7:0] dat;
    logic            rdy0, rdy1, bsy0, bsy1, sclk0, sclk1, ss0, ss1, mosi0, mosi1;
    logic [1:0]      rdy, bsy, sclk, ss, mosi;
    assign rdy  = {rdy1, rdy0};
    assign bsy  = {bsy1, bsy0};
    assign sclk = {sclk1, sclk0};
    assign ss   = {ss1, ss0};
    assign mosi = {mosi1, mosi0};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    logic [3:0] req_a [8];
    logic [7:0] req_v [8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    spi_display_master #(.CLK_DIV(4), .GAP_CYCLES(4), .FIFO_DEPTH(4)) dut (
        .block_clk_i(clk), .rst_low_i(rst_n),
        .req_valid_i(vld[0]), .req_addr_i(adr[0]), .req_data_i(dat[0]),
        .req_ready_o(rdy0), .busy_o(bsy0),
        .spi_sclk_o(sclk0), .spi_ss_o(ss0), .spi_mosi_o(mosi0)
    );

    spi_display_master #(.CLK_DIV(2), .GAP_CYCLES(2), .FIFO_DEPTH(4)) dut_fast (
        .block_clk_i(clk), .rst_low_i(rst_n),
        .req_valid_i(vld[1]), .req_addr_i(adr[1]), .req_data_i(dat[1]),
        .req_ready_o(rdy1), .busy_o(bsy1),
        .spi_sclk_o(sclk1), .spi_ss_o(ss1), .spi_mosi_o(mosi1)
    );

    // Slave-side reference: every accepted request becomes an expected frame;
    // SS-low windows are decoded on SCLK rises and timed against CLK_DIV/GAP.
    for (genvar d = 0; d < 2; d++) begin : mon
        localparam int CDV = (d == 0) ? 4 : 2;
        localparam int GCV = (d == 0) ? 4 : 2;
        logic [15:0] exp_q[$];
        int          acc_q[$];
        int          fall_q[$];
        logic [7:0]  regs [16];
        logic        psclk = 1'b1, pss = 1'b1;
        logic [15:0] word = '0, last_word = '0;
        int nbits = 0, sslen = 0, lowlen = 0, hilen = 0, gaplen = 1000, nwrites = 0;

        always @(negedge clk) begin
            if (!rst_n) begin
                exp_q.delete();
                nbits = 0; sslen = 0; lowlen = 0; hilen = 0; gaplen = 1000;
                psclk = 1'b1; pss = 1'b1;
                for (int i = 0; i < 16; i++) regs[i] = '0;
            end else begin
                if (vld[d] && rdy[d]) begin
                    exp_q.push_back({4'b0001, adr[d], dat[d]});
                    acc_q.push_back(cyc + 1);
                end
                if (pss && !ss[d]) begin
                    fall_q.push_back(cyc);
                    check("gap_min", gaplen >= GCV, 1);
                    check("busy_in_frame", bsy[d], 1);
                    nbits = 0; sslen = 0; lowlen = 0; hilen = 0;
                end
                if (!ss[d]) begin
                    sslen++;
                    if (sclk[d]) hilen++; else lowlen++;
                    if (!psclk && sclk[d]) begin
                        check("low_phase", lowlen, CDV);
                        lowlen = 0;
                        word = {word[14:0], mosi[d]};
                        nbits++;
                    end
                    if (psclk && !sclk[d] && !pss) begin
                        check("high_phase", hilen - 0, CDV);
                        hilen = 0;
                    end else if (psclk && !sclk[d]) begin
                        hilen = 0;
                    end
                end else begin
                    gaplen++;
                end
                if (!pss && ss[d]) begin
                    check("bit_count", nbits, 16);
                    check("ss_low_len", sslen, 34 * CDV);
                    if (exp_q.size() == 0) check("unexpected_frame", word, 16'hxxxx);
                    else check("frame", word, exp_q.pop_front());
                    last_word = word;
                    if (word[15:12] == 4'b0001 && word[11:8] <= 4'd9) begin
                        regs[word[11:8]] = word[7:0];
                        nwrites++;
                    end
                    gaplen = 1;
                end
                psclk = sclk[d];
                pss   = ss[d];
            end
        end
    end

    task automatic send_seq(input int d, input int n);
        int k;
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            vld[d] = 1'b1; adr[d] = req_a[i]; dat[d] = req_v[i];
            k = 0;
            @(negedge clk);
            while (!rdy[d] && k < 2000) begin @(negedge clk); k++; end
            if (k >= 2000) check("accept_timeout", 0, 1);
            @(posedge clk); #1;
        end
        vld[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        repeat (3) @(negedge clk);
        while (bsy[d] && n < 5000) begin @(negedge clk); n++; end
        if (n >= 5000) check("idle_timeout", 0, 1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw, e, k;
        rst_n = 1'b0; vld = '0; adr = '0; dat = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", rdy0, 0);
        check("rst_sclk", sclk0, 1);
        check("rst_ss", ss0, 1);
        check("rst_mosi", mosi0, 1);
        check("rst_busy", bsy0, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", rdy0, 1);
        check("busy_after_rst", bsy0, 0);

        // single frame, addr 1 / data 0x5A
        mon[0].acc_q.delete(); mon[0].fall_q.delete();
        req_a[0] = 4'h1; req_v[0] = 8'h5A;
        send_seq(0, 1);
        wait_idle(0);
        check("t1_frames", mon[0].fall_q.size(), 1);
        if (mon[0].fall_q.size() > 0 && mon[0].acc_q.size() > 0)
            check("latency", mon[0].fall_q[0] - mon[0].acc_q[0], 2);
        check("word_115a", mon[0].last_word, 16'h115A);
        check("digit1", mon[0].regs[1], 8'h5A);
        check("idle_ss", ss0, 1);

        // five back-to-back random requests, valid held high
        mon[0].acc_q.delete(); mon[0].fall_q.delete();
        for (int i = 0; i < 5; i++) begin
            req_a[i] = 4'($urandom_range(9, 1));
            req_v[i] = 8'($urandom);
        end
        send_seq(0, 5);
        wait_idle(0);
        check("t2_accepts", mon[0].acc_q.size(), 5);
        check("t2_frames", mon[0].fall_q.size(), 5);
        if (mon[0].acc_q.size() == 5 && mon[0].fall_q.size() == 5) begin
            for (int i = 1; i < 5; i++) begin
`ifdef SPI_MASTER_FIFO_EN
                e = i;
`else
                e = 2 + (i - 1) * P0;
`endif
                check("accept_time", mon[0].acc_q[i] - mon[0].acc_q[0], e);
                check("frame_period", mon[0].fall_q[i] - mon[0].fall_q[i-1], P0);
            end
            check("t2_latency", mon[0].fall_q[0] - mon[0].acc_q[0], 2);
        end
        check("t2_last_digit", mon[0].regs[req_a[4]], req_v[4]);

        // out-of-range address: sent verbatim, ignored by the slave
        nw = mon[0].nwrites;
        req_a[0] = 4'hC; req_v[0] = 8'hFF;
        send_seq(0, 1);
        wait_idle(0);
        check("word_1cff", mon[0].last_word, 16'h1CFF);
        check("addr_c_no_write", mon[0].nwrites, nw);

        // reset during frame bit 7
        req_a[0] = 4'($urandom_range(9, 1)); req_v[0] = 8'($urandom);
        send_seq(0, 1);
        k = 0;
        while (mon[0].nbits < 8 && k < 2000) begin @(negedge clk); k++; end
        if (k >= 2000) check("bit7_timeout", 0, 1);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ss", ss0, 1);
        check("mid_rst_sclk", sclk0, 1);
        check("mid_rst_mosi", mosi0, 1);
        check("mid_rst_busy", bsy0, 0);
        check("mid_rst_ready", rdy0, 0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        nw = mon[0].nwrites;
        req_a[0] = 4'($urandom_range(9, 1)); req_v[0] = 8'($urandom);
        send_seq(0, 1);
        wait_idle(0);
        check("post_rst_word", mon[0].last_word, {4'b0001, req_a[0], req_v[0]});
        check("post_rst_digit", mon[0].regs[req_a[0]], req_v[0]);
        check("post_rst_writes", mon[0].nwrites, nw + 1);

        // CLK_DIV=2, GAP_CYCLES=2 instance, two back-to-back frames
        mon[1].acc_q.delete(); mon[1].fall_q.delete();
        req_a[0] = 4'($urandom_range(4, 1)); req_v[0] = 8'($urandom);
        req_a[1] = 4'($urandom_range(9, 5)); req_v[1] = 8'($urandom);
        send_seq(1, 2);
        wait_idle(1);
        check("fast_frames", mon[1].fall_q.size(), 2);
        if (mon[1].fall_q.size() == 2)
            check("fast_period", mon[1].fall_q[1] - mon[1].fall_q[0], P1);
        check("fast_digit_a", mon[1].regs[req_a[0]], req_v[0]);
        check("fast_digit_b", mon[1].regs[req_a[1]], req_v[1]);
        check("fast_idle_ss", ss1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_display_master.md
# spi_display_master

SPI master that turns parallel register-write requests into 16-bit display-controller frames. It sits directly upstream of the Nexys4 display SPI slave and drives its `spi_sclk`/`spi_ss`/`spi_mosi` inputs from the same `block_clk_i` domain. Requests come from the processor-side bus glue over a valid/ready handshake. They are queued, serialised MSB first, and separated by an inter-frame gap so the slave's bit counter clears between frames.

## Interface
- `CLK_DIV`, default 4: SCLK half-period in `block_clk_i` cycles; minimum 2.
- `GAP_CYCLES`, default 4: SS-high cycles between frames; minimum 2.
- `FIFO_DEPTH`, default 4: request queue depth, power of two; used only with `SPI_MASTER_FIFO_EN`.
- `block_clk_i` input 1: sole clock. All logic uses its rising edge.
- `rst_low_i` input 1: reset, asynchronous, active-low.
- `req_valid_i` input 1: a write request is present.
- `req_addr_i` input 4: target register address (0 = enable, 1–8 = digits, 9 = radix).
- `req_data_i` input 8: register value.
- `req_ready_o` output 1: the request can be accepted. A transfer happens when `req_valid_i` and `req_ready_o` are both high on a clock edge.
- `busy_o` output 1: high while the queue is non-empty or a frame/gap is in progress.
- `spi_sclk_o` output 1: SPI clock; idles high.
- `spi_ss_o` output 1: slave select; active low, idles high.
- `spi_mosi_o` output 1: serial data; idles high.

## Operation
- Frame word: `{4'b0001, addr[3:0], data[7:0]}`, sent bit 15 first. The command nibble is fixed.
- Addresses 10–15 are sent unchanged. The slave ignores them.
- All SPI outputs come straight from flops, with no combinational path to the pins.
- State machine states: IDLE, SETUP, LOW, HIGH, HOLD, GAP.
  - IDLE: SS=1, SCLK=1, MOSI=1. When the queue is non-empty, pop the head into the 16-bit shift register, load bit index 15, go to SETUP.
  - SETUP: SS=0, SCLK=1, MOSI=bit 15, held for CLK_DIV cycles, then go to LOW.
  - LOW: SCLK=0, MOSI=current bit, held for CLK_DIV cycles, then go to HIGH. The SCLK rising edge at HIGH entry is the slave's sample point.
  - HIGH: SCLK=1, held for CLK_DIV cycles.
    - If bit index is 0, go to HOLD.
    - Otherwise decrement the index, shift, go to LOW.
    - MOSI changes only on HIGH→LOW transitions.
  - HOLD: SS=0, SCLK=1, held for CLK_DIV cycles, then go to GAP.
  - GAP: SS=1, SCLK=1, MOSI=1, held for GAP_CYCLES cycles, then go to IDLE.
- Exactly 16 SCLK rising edges occur per SS-low window. The slave never sees a partial frame except across a reset.
- Queue:
  - `req_ready_o = !full`.
  - A push and a pop in the same cycle are both honoured. When the queue is full, ready is low and simultaneous push/pop cannot occur.
  - Head-of-queue pop happens only in IDLE.
- `busy_o = (state != IDLE) | !empty`, registered.
- One shared phase counter, width `$clog2(max(CLK_DIV, GAP_CYCLES))+1`. It reloads on every state change and never wraps mid-phase.

## Timing
- Reset values:
  - `spi_sclk_o`=1, `spi_ss_o`=1, `spi_mosi_o`=1, `busy_o`=0.
  - `req_ready_o`=1 when deasserted; held at 0 while `rst_low_i` is low.
  - Queue empty, state IDLE.
- Latency, request to frame: a request accepted at edge N into an empty, idle block makes SS fall at edge N+2. That is one cycle to write the queue, then one cycle for the IDLE pop to register SS.
- SS-low duration: 34·CLK_DIV cycles (SETUP + 16×2 + HOLD).
- Frame period for back-to-back requests: 34·CLK_DIV + GAP_CYCLES + 1 cycles. The +1 is the IDLE pop cycle.
- Defaults give 136 SS-low cycles and a 141-cycle period. SCLK = f_clk/8.
- Reset mid-frame:
  - All outputs return to idle values asynchronously.
  - The queue is flushed and the frame is abandoned. The slave shares the reset, so its state is cleared too.
- A request arriving during GAP is queued and sent after GAP completes. There is no gap shortening.

## Configuration
- Macro `SPI_MASTER_FIFO_EN`.
- Defined: a FIFO_DEPTH-entry circular queue with wrap-around read/write pointers and an occupancy counter. `full` means count == FIFO_DEPTH.
- Undefined: a single holding register, so depth is 1 and FIFO_DEPTH is ignored.
  - `req_ready_o` is high only while the register is empty.
  - The register is popped in IDLE, so a new request can be accepted during the current frame.
- The SPI waveform and frame timing are identical in both builds.

## Test plan
- Reset release, then one request addr=0x1, data=0x5A:
  - MOSI samples at the 16 SCLK rises are `0001_0001_0101_1010`.
  - SS is low for exactly 136 cycles; `busy_o` falls after GAP.
  - With the slave model attached, its digit-1 register equals 0x5A.
- Five back-to-back requests with the FIFO enabled (depth 4), valid held high:
  - Four are accepted immediately; the fifth is accepted after the first pop.
  - Frames are sent in order, each 141 cycles apart, with SS high ≥ GAP_CYCLES between them.
- Same stimulus with the macro undefined:
  - `req_ready_o` low after the first accept, high again at the pop in IDLE.
  - All 5 frames are sent in order.
- Address 0xC, data 0xFF: the frame `0x1CFF` is sent and the slave's registers are unchanged.
- Assert `rst_low_i` low during frame bit 7:
  - SS/SCLK/MOSI go high immediately; `busy_o`=0.
  - A request after release produces a complete, correct frame.
- CLK_DIV=2, GAP_CYCLES=2: SCLK high and low phases are each 2 cycles, SS-low is 68 cycles, and the slave still decodes the data correctly.
